scie_arbiter: RTL and testbench

SCIE_ARBITER -- requirements
Module: scie_arbiter

---
 rtl/scie_pkg.sv | 18 +
 rtl/scie_rr_arb2.sv | 19 +
 rtl/scie_arbiter.sv | 153 +++++++++++++++
 tb/tb_scie_arbiter.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scie_pkg.sv
// Shared types and constants for the SCIE request arbiter.
// Optional opcode check is enabled by SCIE_ARB_OPCODE_CHECK_EN.
package scie_pkg;

    localparam int         XLEN_DEF    = 32;
    localparam logic [6:0] SCIE_OPCODE = 7'h7B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    function automatic logic is_scie(input logic [31:0] insn);
        return insn[6:0] == SCIE_OPCODE;
    endfunction

endpackage

// File: rtl/scie_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins,
// a tie is broken by the pointer.
module scie_rr_arb2
    import scie_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
            default: o_gnt = i_req;
        endcase
    end

endmodule

// File: rtl/scie_arbiter.sv
// Shares one SCIE datapath between two requesters (IDLE/EXEC/RESP).
// Define SCIE_ARB_OPCODE_CHECK_EN to reject non custom-3 opcodes.
module scie_arbiter
    import scie_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int LATENCY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        io_req_valid,
    output logic [1:0]        io_req_ready,
    input  logic [63:0]       io_req_insn,
    input  logic [2*XLEN-1:0] io_req_rs1,
    input  logic [2*XLEN-1:0] io_req_rs2,
    output logic [1:0]        io_resp_valid,
    input  logic [1:0]        io_resp_ready,
    output logic [XLEN-1:0]   io_resp_rd,
    output logic              io_resp_illegal,
    output logic [31:0]       io_scie_insn,
    output logic [XLEN-1:0]   io_scie_rs1,
    output logic [XLEN-1:0]   io_scie_rs2,
    input  logic [XLEN-1:0]   io_scie_rd
);

    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    state_e          r_state;
    state_e          w_next;
    logic            r_ptr;
    logic            r_idx;
    logic [31:0]     r_insn;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_rd;
    logic [CW-1:0]   r_cnt;

    logic [1:0]      w_gnt;
    logic            w_sel;
    logic            w_accept;
    logic            w_done;
    logic            w_cnt_zero;
    logic            w_legal;
    logic [31:0]     w_insn;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;

    scie_rr_arb2 u_arb (
        .i_req (io_req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_sel      = w_gnt[1];
    assign w_insn     = w_sel ? io_req_insn[63:32] : io_req_insn[31:0];
    assign w_rs1      = w_sel ? io_req_rs1[2*XLEN-1:XLEN] : io_req_rs1[XLEN-1:0];
    assign w_rs2      = w_sel ? io_req_rs2[2*XLEN-1:XLEN] : io_req_rs2[XLEN-1:0];
    assign w_accept   = (r_state == ST_IDLE) && (|io_req_valid);
    assign w_done     = (r_state == ST_RESP) && io_resp_ready[r_idx];
    assign w_cnt_zero = (r_cnt == '0);

`ifdef SCIE_ARB_OPCODE_CHECK_EN
    logic r_illegal;

    assign w_legal         = is_scie(w_insn);
    assign io_resp_illegal = r_illegal;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= ~w_legal;
        end
    end
`else
    assign w_legal         = 1'b1;
    assign io_resp_illegal = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        io_req_ready  = 2'b00;
        io_resp_valid = 2'b00;
        case (r_state)
            ST_IDLE: begin
                io_req_ready = reset ? 2'b00 : w_gnt;
                if (w_accept) begin
                    w_next = w_legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                if (w_cnt_zero) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!reset) begin
                    io_resp_valid = r_idx ? 2'b10 : 2'b01;
                end
                if (w_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Rejected opcodes never reach the datapath, so insn stays 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr  <= 1'b0;
            r_idx  <= 1'b0;
            r_insn <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_idx  <= w_sel;
                r_insn <= w_legal ? w_insn : 32'h0;
                r_rs1  <= w_rs1;
                r_rs2  <= w_rs2;
                r_rd   <= '0;
                r_cnt  <= CW'(LATENCY);
            end
            if (r_state == ST_EXEC) begin
                if (w_cnt_zero) begin
                    r_rd <= io_scie_rd;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            if (w_done) begin
                r_ptr <= ~r_idx;
            end
        end
    end

    assign io_scie_insn = r_insn;
    assign io_scie_rs1  = r_rs1;
    assign io_scie_rs2  = r_rs2;
    assign io_resp_rd   = r_rd;

endmodule

// File: tb/tb_scie_arbiter.sv
// Bench for scie_arbiter: unpipelined instance A, LATENCY=2 instance B,
// both attached to a ReLU datapath model.
module tb_scie_arbiter;

    localparam int XLEN  = 32;
    localparam int LAT_A = 0;
    localparam int LAT_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            a_rst, b_rst;
    logic [1:0]      a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [1:0]      b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [63:0]     a_req_insn, a_req_rs1, a_req_rs2;
    logic [63:0]     b_req_insn, b_req_rs1, b_req_rs2;
    logic [XLEN-1:0] a_resp_rd, a_scie_rs1, a_scie_rs2, a_scie_rd;
    logic [XLEN-1:0] b_resp_rd, b_scie_rs1, b_scie_rs2, b_scie_rd;
    logic [31:0]     a_scie_insn, b_scie_insn;
    logic            a_illegal, b_illegal;

    int   checks   = 0;
    int   failures = 0;
    logic m_ptr;
    logic m_ptr_b;

    function automatic logic [31:0] relu(input logic [31:0] x);
        return x[31] ? 32'd0 : x;
    endfunction

    function automatic logic legal(input logic [31:0] insn);
`ifdef SCIE_ARB_OPCODE_CHECK_EN
        return insn[6:0] == 7'h7B;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [1:0] winner(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // A: combinational ReLU. B: ReLU with two register stages.
    assign a_scie_rd = relu(a_scie_rs1);

    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1 <= relu(b_scie_rs1);
        p2 <= p1;
    end
    assign b_scie_rd = p2;

    scie_arbiter #(.XLEN(XLEN), .LATENCY(LAT_A)) u_dut (
        .clock           (clk),
        .reset           (a_rst),
        .io_req_valid    (a_req_valid),
        .io_req_ready    (a_req_ready),
        .io_req_insn     (a_req_insn),
        .io_req_rs1      (a_req_rs1),
        .io_req_rs2      (a_req_rs2),
        .io_resp_valid   (a_resp_valid),
        .io_resp_ready   (a_resp_ready),
        .io_resp_rd      (a_resp_rd),
        .io_resp_illegal (a_illegal),
        .io_scie_insn    (a_scie_insn),
        .io_scie_rs1     (a_scie_rs1),
        .io_scie_rs2     (a_scie_rs2),
        .io_scie_rd      (a_scie_rd)
    );

    scie_arbiter #(.XLEN(XLEN), .LATENCY(LAT_B)) u_dut_l2 (
        .clock           (clk),
        .reset           (b_rst),
        .io_req_valid    (b_req_valid),
        .io_req_ready    (b_req_ready),
        .io_req_insn     (b_req_insn),
        .io_req_rs1      (b_req_rs1),
        .io_req_rs2      (b_req_rs2),
        .io_resp_valid   (b_resp_valid),
        .io_resp_ready   (b_resp_ready),
        .io_resp_rd      (b_resp_rd),
        .io_resp_illegal (b_illegal),
        .io_scie_insn    (b_scie_insn),
        .io_scie_rs1     (b_scie_rs1),
        .io_scie_rs2     (b_scie_rs2),
        .io_scie_rd      (b_scie_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!(|a_resp_valid) && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!(|b_resp_valid) && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b1;
        a_req_valid = 2'b11;
        #1;
        checks++;
        if (a_req_ready !== 2'b00) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=00", a_req_ready);
        end
        tick();
        tick();
        checks++;
        if (a_resp_valid !== 2'b00 || a_resp_rd !== 32'd0 || a_illegal !== 1'b0) begin
            failures++;
            $display("FAIL rst_resp got=%b/%h/%b exp=00/0/0", a_resp_valid, a_resp_rd, a_illegal);
        end
        checks++;
        if (a_scie_insn !== 32'd0 || a_scie_rs1 !== 32'd0 || a_scie_rs2 !== 32'd0) begin
            failures++;
            $display("FAIL rst_scie got=%h/%h/%h exp=0", a_scie_insn, a_scie_rs1, a_scie_rs2);
        end
        a_rst = 1'b0;
        a_req_valid = 2'b00;
        m_ptr = 1'b0;
        tick();
    endtask

    task automatic test_both();
        int n;
        a_req_insn = {32'h7B, 32'h7B};
        a_req_rs1  = {32'd8192, -32'sd5120};
        a_req_rs2  = 64'd0;
        a_req_valid = 2'b11;
        #1;
        checks++;
        if (a_req_ready !== 2'b01) begin
            failures++;
            $display("FAIL both_grant0 got=%b exp=01", a_req_ready);
        end
        tick();
        a_req_valid = 2'b10;
        wait_a(n);
        checks++;
        if (a_resp_valid !== 2'b01 || a_resp_rd !== 32'd0) begin
            failures++;
            $display("FAIL both_resp0 got=%b/%h exp=01/0", a_resp_valid, a_resp_rd);
        end
        a_resp_ready = 2'b01;
        tick();
        a_resp_ready = 2'b00;
        m_ptr = 1'b1;
        checks++;
        if (a_req_ready !== 2'b10) begin
            failures++;
            $display("FAIL both_grant1 got=%b exp=10", a_req_ready);
        end
        tick();
        a_req_valid = 2'b00;
        wait_a(n);
        checks++;
        if (a_resp_valid !== 2'b10 || a_resp_rd !== 32'd8192) begin
            failures++;
            $display("FAIL both_resp1 got=%b/%h exp=10/2000", a_resp_valid, a_resp_rd);
        end
        a_resp_ready = 2'b10;
        tick();
        a_resp_ready = 2'b00;
        m_ptr = 1'b0;
    endtask

    task automatic test_single();
        int n;
        a_req_insn = {32'h0, 32'h7B};
        a_req_rs1  = {32'd0, 32'd3328};
        a_req_valid = 2'b01;
        #1;
        checks++;
        if (a_req_ready !== 2'b01) begin
            failures++;
            $display("FAIL single_ready got=%b exp=01", a_req_ready);
        end
        tick();
        a_req_valid = 2'b00;
        wait_a(n);
        checks++;
        if (n !== LAT_A + 1) begin
            failures++;
            $display("FAIL single_lat got=%0d exp=%0d", n, LAT_A + 1);
        end
        checks++;
        if (a_resp_valid !== 2'b01 || a_resp_rd !== 32'd3328) begin
            failures++;
            $display("FAIL single_rd got=%b/%0d exp=01/3328", a_resp_valid, a_resp_rd);
        end
        a_resp_ready = 2'b01;
        tick();
        a_resp_ready = 2'b00;
        m_ptr = 1'b1;
        checks++;
        if (a_resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL single_done got=%b exp=00", a_resp_valid);
        end
    endtask

    task automatic test_hold();
        int n;
        logic [31:0] insn = 32'h0123_407B;
        a_req_insn = {insn, 32'h0};
        a_req_rs1  = {32'h0000_1234, 32'h0};
        a_req_rs2  = {32'h0000_5678, 32'h0};
        a_req_valid = 2'b10;
        tick();
        a_req_valid = 2'b11;
        wait_a(n);
        for (int i = 0; i < 5; i++) begin
            a_resp_ready = 2'b01;
            #1;
            checks++;
            if (a_resp_valid !== 2'b10 || a_resp_rd !== 32'h1234 || a_req_ready !== 2'b00) begin
                failures++;
                $display("FAIL hold_resp[%0d] got=%b/%h/%b exp=10/1234/00",
                         i, a_resp_valid, a_resp_rd, a_req_ready);
            end
            checks++;
            if (a_scie_insn !== insn || a_scie_rs1 !== 32'h1234 || a_scie_rs2 !== 32'h5678) begin
                failures++;
                $display("FAIL hold_scie[%0d] got=%h/%h/%h exp=%h/1234/5678",
                         i, a_scie_insn, a_scie_rs1, a_scie_rs2, insn);
            end
            tick();
        end
        a_req_valid = 2'b00;
        a_resp_ready = 2'b10;
        tick();
        a_resp_ready = 2'b00;
        m_ptr = 1'b0;
    endtask

    task automatic test_illegal();
        int n;
        logic [31:0] insn = 32'h33;
        logic        ok;
        ok = legal(insn);
        a_req_insn = {32'h0, insn};
        a_req_rs1  = {32'd0, 32'd100};
        a_req_valid = 2'b01;
        tick();
        a_req_valid = 2'b00;
        wait_a(n);
        checks++;
        if (n !== (ok ? LAT_A + 1 : 0)) begin
            failures++;
            $display("FAIL illegal_lat got=%0d exp=%0d", n, ok ? LAT_A + 1 : 0);
        end
        checks++;
        if (a_illegal !== ~ok || a_resp_rd !== (ok ? 32'd100 : 32'd0)) begin
            failures++;
            $display("FAIL illegal_resp got=%b/%0d exp=%b/%0d",
                     a_illegal, a_resp_rd, ~ok, ok ? 100 : 0);
        end
        checks++;
        if (a_scie_insn !== (ok ? insn : 32'h0)) begin
            failures++;
            $display("FAIL illegal_insn got=%h exp=%h", a_scie_insn, ok ? insn : 32'h0);
        end
        a_resp_ready = 2'b01;
        tick();
        a_resp_ready = 2'b00;
        m_ptr = 1'b1;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int resps = 0;
        int at[4];
        a_req_insn = {32'h7B, 32'h0};
        a_req_rs1  = {32'd4352, 32'd0};
        a_req_valid = 2'b10;
        a_resp_ready = 2'b10;
        for (int c = 0; c < 60 && resps < 4; c++) begin
            #1;
            if (a_req_ready[1] && acc < 4) begin
                at[acc] = c;
                acc++;
            end
            if (a_resp_valid[1]) begin
                checks++;
                if (a_resp_rd !== 32'd4352) begin
                    failures++;
                    $display("FAIL b2b_rd[%0d] got=%0d exp=4352", resps, a_resp_rd);
                end
                resps++;
            end
            tick();
            if (acc == 4) a_req_valid = 2'b00;
        end
        a_req_valid = 2'b00;
        a_resp_ready = 2'b00;
        m_ptr = 1'b0;
        checks++;
        if (resps !== 4 || acc !== 4) begin
            failures++;
            $display("FAIL b2b_count got=%0d/%0d exp=4/4", acc, resps);
        end
        for (int i = 1; i < acc; i++) begin
            checks++;
            if (at[i] - at[i-1] !== LAT_A + 3) begin
                failures++;
                $display("FAIL b2b_interval[%0d] got=%0d exp=%0d", i, at[i] - at[i-1], LAT_A + 3);
            end
        end
    endtask

    task automatic test_random();
        int n, d;
        logic [1:0]  v, g;
        logic        w, ok;
        logic [31:0] i0, i1, r0, r1, iw, rw;
        for (int t = 0; t < 30; t++) begin
            v  = 2'($urandom_range(1, 3));
            i0 = ($urandom_range(0, 3) == 0) ? 32'h33 : 32'h7B;
            i1 = ($urandom_range(0, 3) == 0) ? 32'h33 : 32'h7B;
            r0 = $urandom;
            r1 = $urandom;
            a_req_insn = {i1, i0};
            a_req_rs1  = {r1, r0};
            a_req_rs2  = {$urandom, $urandom};
            a_req_valid = v;
            g  = winner(v, m_ptr);
            w  = g[1];
            iw = w ? i1 : i0;
            rw = w ? r1 : r0;
            ok = legal(iw);
            #1;
            checks++;
            if (a_req_ready !== g) begin
                failures++;
                $display("FAIL rnd_grant[%0d] got=%b exp=%b", t, a_req_ready, g);
            end
            tick();
            a_req_valid = 2'b00;
            wait_a(n);
            checks++;
            if (n !== (ok ? LAT_A + 1 : 0) || a_resp_valid !== g) begin
                failures++;
                $display("FAIL rnd_lat[%0d] got=%0d/%b exp=%0d/%b",
                         t, n, a_resp_valid, ok ? LAT_A + 1 : 0, g);
            end
            checks++;
            if (a_resp_rd !== (ok ? relu(rw) : 32'd0) || a_illegal !== ~ok) begin
                failures++;
                $display("FAIL rnd_rd[%0d] got=%h/%b exp=%h/%b",
                         t, a_resp_rd, a_illegal, ok ? relu(rw) : 32'd0, ~ok);
            end
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
                a_resp_ready = ~g;
                tick();
                checks++;
                if (a_resp_valid !== g) begin
                    failures++;
                    $display("FAIL rnd_hold[%0d] got=%b exp=%b", t, a_resp_valid, g);
                end
            end
            a_resp_ready = g;
            tick();
            a_resp_ready = 2'b00;
            m_ptr = ~w;
            checks++;
            if (a_resp_valid !== 2'b00) begin
                failures++;
                $display("FAIL rnd_done[%0d] got=%b exp=00", t, a_resp_valid);
            end
        end
    endtask

    task automatic test_reset_exec();
        int n;
        b_rst = 1'b1;
        tick();
        tick();
        b_rst = 1'b0;
        m_ptr_b = 1'b0;
        b_req_insn = {32'h7B, 32'h7B};
        b_req_rs1  = {32'd99, 32'd77};
        b_req_valid = 2'b01;
        tick();
        b_req_valid = 2'b00;
        wait_b(n);
        checks++;
        if (n !== LAT_B + 1 || b_resp_rd !== 32'd77) begin
            failures++;
            $display("FAIL l2_first got=%0d/%0d exp=%0d/77", n, b_resp_rd, LAT_B + 1);
        end
        b_resp_ready = 2'b01;
        tick();
        b_resp_ready = 2'b00;
        m_ptr_b = 1'b1;
        b_req_valid = 2'b10;
        #1;
        checks++;
        if (b_req_ready !== 2'b10) begin
            failures++;
            $display("FAIL l2_grant1 got=%b exp=10", b_req_ready);
        end
        tick();
        b_req_valid = 2'b11;
        tick();
        b_rst = 1'b1;
        #1;
        checks++;
        if (b_req_ready !== 2'b00 || b_resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL l2_in_rst got=%b/%b exp=00/00", b_req_ready, b_resp_valid);
        end
        tick();
        b_rst = 1'b0;
        b_req_valid = 2'b00;
        m_ptr_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (b_resp_valid !== 2'b00) begin
                failures++;
                $display("FAIL l2_no_resp[%0d] got=%b exp=00", i, b_resp_valid);
            end
        end
        b_req_valid = 2'b11;
        #1;
        checks++;
        if (b_req_ready !== winner(2'b11, m_ptr_b)) begin
            failures++;
            $display("FAIL l2_ptr got=%b exp=01", b_req_ready);
        end
        tick();
        b_req_valid = 2'b00;
        wait_b(n);
        checks++;
        if (n !== LAT_B + 1 || b_resp_valid !== 2'b01 || b_resp_rd !== 32'd77) begin
            failures++;
            $display("FAIL l2_after got=%0d/%b/%0d exp=%0d/01/77",
                     n, b_resp_valid, b_resp_rd, LAT_B + 1);
        end
        b_resp_ready = 2'b01;
        tick();
        b_resp_ready = 2'b00;
    endtask

    initial begin
        a_rst = 1'b1;
        b_rst = 1'b1;
        a_req_valid = 2'b00;
        b_req_valid = 2'b00;
        a_resp_ready = 2'b00;
        b_resp_ready = 2'b00;
        a_req_insn = '0;
        a_req_rs1 = '0;
        a_req_rs2 = '0;
        b_req_insn = '0;
        b_req_rs1 = '0;
        b_req_rs2 = '0;
        m_ptr = 1'b0;
        m_ptr_b = 1'b0;
        test_reset();
        test_both();
        test_single();
        test_back_to_back();
        test_hold();
        test_illegal();
        test_random();
        test_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
